// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: groups the receiver-side byte strobe, the FWFT byte
// stream towards the CPU/bus side and the overflow status of uart_rx_fifo.
// The slave modport is the FIFO side; the master modport is its environment.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          in_valid;
    logic [7:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [AW:0]   level;
    logic          overflow;
    logic [7:0]    drop_count;
    logic          overflow_clear;

    modport slave (
        input  in_valid, in_data, out_ready, overflow_clear,
        output out_valid, out_data, level, overflow, drop_count
    );

    modport master (
        output in_valid, in_data, out_ready, overflow_clear,
        input  out_valid, out_data, level, overflow, drop_count
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: power-of-two circular byte FIFO behind the UART receiver.
// Bytes arrive as one-cycle strobes and leave over a first-word-fall-through
// valid/ready stream with a registered head byte. Bytes offered while full
// (and not relieved by a same-cycle pop) are discarded.
// Optional feature macro: UART_RX_FIFO_OVERFLOW_EN enables the sticky
// overflow flag and the saturating 8-bit drop counter; without it both
// outputs are tied low and overflow_clear is ignored.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              resetn,
    uart_rx_fifo_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wp_q, wp_d;
    logic [AW:0] rp_q, rp_d;
    logic [AW:0] rp_inc;
    logic [7:0]  mem_q [DEPTH];
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        empty, full, pop, push;

    assign rp_inc = rp_q + PTR_ONE;
    assign empty  = (wp_q == rp_q);
    assign full   = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    assign pop    = out_valid_q && bus.out_ready;
    // A same-cycle pop frees a slot, so a full FIFO still accepts the byte.
    assign push   = bus.in_valid && (!full || pop);

    // Next-state for pointers and the registered head byte.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wp_d        = wp_q;
        rp_d        = rp_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (push) begin
            wp_d = wp_q + PTR_ONE;
        end
        if (pop) begin
            rp_d = rp_inc;
            // Another byte already stored behind the head: restage it now for back-to-back pops.
            if (wp_q != rp_inc) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_q[rp_inc[AW-1:0]];
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (!out_valid_q && !empty) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[rp_q[AW-1:0]];
        end
    end

    // Pointer and output-stage registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            wp_q        <= '0;
            rp_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Byte storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the array is not reset; stale entries are never read because the pointers are.
        if (push) begin
            mem_q[wp_q[AW-1:0]] <= bus.in_data;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.level     = wp_q - rp_q;

`ifdef UART_RX_FIFO_OVERFLOW_EN
    logic       drop;
    logic       overflow_q, overflow_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    assign drop = bus.in_valid && full && !pop;

    // Sticky flag and saturating counter; a drop in the clear cycle wins.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (bus.overflow_clear) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (bus.overflow_clear) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    // Overflow status registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_cnt_q;
`else
    logic unused_overflow_clear;
    assign unused_overflow_clear = bus.overflow_clear;
    assign bus.overflow          = 1'b0;
    assign bus.drop_count        = 8'h00;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized checks of uart_rx_fifo against a
// queue-based reference model (byte order, occupancy, drop accounting).
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    // Reference model state.
    logic [7:0] q[$];
    bit         m_ovf;
    int         m_cnt;
    int         gap;
    logic [7:0] last_out;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, update model, check after the edge.
    task automatic step(input logic inv, input logic [7:0] d, input logic rdy, input logic clr);
        bit         pop, push, stalled;
        logic [7:0] held;
        @(negedge clk);
        bus.in_valid       = inv;
        bus.in_data        = d;
        bus.out_ready      = rdy;
        bus.overflow_clear = clr;
        pop     = (bus.out_valid === 1'b1) && rdy;
        stalled = (bus.out_valid === 1'b1) && !rdy;
        held    = bus.out_data;
        push    = inv && ((q.size() < DEPTH) || pop);
        if (pop) begin
            last_out = bus.out_data;
            q.delete(0);
        end
        if (push) q.push_back(d);
        if (inv && !push) begin
            m_ovf = 1'b1;
            m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
        bus.in_valid       = 1'b0;
        bus.out_ready      = 1'b0;
        bus.overflow_clear = 1'b0;
        check("level", 32'(bus.level), 32'(q.size()));
        check("overflow", 32'(bus.overflow), OVF_EN ? 32'(m_ovf) : 32'd0);
        check("drop_count", 32'(bus.drop_count), OVF_EN ? 32'(m_cnt) : 32'd0);
        check("valid_when_empty", 32'(bus.out_valid === 1'b1 && q.size() == 0), 32'd0);
        if (bus.out_valid === 1'b1 && q.size() > 0) check("head_data", 32'(bus.out_data), 32'(q[0]));
        if (stalled) check("stall_stable", 32'(bus.out_data), 32'(held));
        if (q.size() > 0 && bus.out_valid !== 1'b1) gap++;
        else gap = 0;
        check("stage_gap", 32'(gap > 1), 32'd0);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
        gap   = 0;
    endtask

    initial begin
        model_reset();
        last_out           = 8'h00;
        resetn             = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_data        = 8'h00;
        bus.out_ready      = 1'b0;
        bus.overflow_clear = 1'b0;
        #12;
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'h00);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_drop_count", 32'(bus.drop_count), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Single byte: one-cycle staging latency, then pop empties the FIFO.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        check("single_lat0_valid", 32'(bus.out_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_data", 32'(bus.out_data), 32'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("single_pop_valid", 32'(bus.out_valid), 32'd0);
        check("single_pop_level", 32'(bus.level), 32'd0);

        // Fill and in-order drain without bubbles.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("fill_level", 32'(bus.level), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check("drain_order", 32'(last_out), 32'(i));
            if (i < DEPTH - 1) check("drain_no_bubble", 32'(bus.out_valid), 32'd1);
        end
        check("drain_level", 32'(bus.level), 32'd0);

        // Overflow: two drops while full, then clear; clear+drop in one cycle.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        step(1'b1, 8'hEF, 1'b0, 1'b0);
        check("ovf_flag", 32'(bus.overflow), OVF_EN ? 32'd1 : 32'd0);
        check("ovf_count", 32'(bus.drop_count), OVF_EN ? 32'd2 : 32'd0);
        check("ovf_head", 32'(bus.out_data), 32'h00);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clear_flag", 32'(bus.overflow), 32'd0);
        check("ovf_clear_count", 32'(bus.drop_count), 32'd0);
        step(1'b1, 8'hE0, 1'b0, 1'b0);
        step(1'b1, 8'hE1, 1'b0, 1'b1);
        check("clr_vs_drop_count", 32'(bus.drop_count), OVF_EN ? 32'd1 : 32'd0);
        for (int i = 0; i < 260; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check("drop_saturate", 32'(bus.drop_count), OVF_EN ? 32'd255 : 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Full with simultaneous pop: push accepted, level stays at DEPTH.
        step(1'b1, 8'h77, 1'b1, 1'b0);
        check("fullpop_level", 32'(bus.level), 32'd16);
        check("fullpop_overflow", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 40 && q.size() > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("fullpop_drained", 32'(q.size()), 32'd0);
        check("fullpop_last", 32'(last_out), 32'h77);

        // Randomized push/pop with back-pressure, wrapping the pointers.
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 40 && q.size() > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("rand_drained", 32'(bus.level), 32'd0);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i + 8'h40), 1'b0, 1'b0);
        step(1'b1, 8'hDD, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("premid_level", 32'(bus.level), 32'd5);
        check("premid_overflow", 32'(bus.overflow), OVF_EN ? 32'd1 : 32'd0);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_level", 32'(bus.level), 32'd0);
        check("async_rst_overflow", 32'(bus.overflow), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst_data", 32'(bus.out_data), 32'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
